// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/load result inputs, issue/decode
// scoreboard lookups and the regfile write port.
interface wb_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int LD_DEPTH = 4
);
  localparam int CW = $clog2(LD_DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic [CW-1:0]   ld_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output ld_ready, rs1_busy, rs2_busy, rd_busy,
    output wb_we, wb_rd, wb_wdata, ld_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  ld_ready, rs1_busy, rs2_busy, rd_busy,
    input  wb_we, wb_rd, wb_wdata, ld_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback stage: merges ALU and buffered load results into the
// single regfile write port and tracks pending destination registers.
module wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int LD_DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(LD_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      mem_rd [LD_DEPTH];
  logic [XLEN-1:0] mem_d  [LD_DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   cnt_q;

  logic            wb_we_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_d_q;
  logic [31:0]     pend_q;
  logic [31:0]     pend_nxt;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            sel_v;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_d;
  logic            wr;

  assign full  = cnt_q == CW'(LD_DEPTH);
  assign empty = cnt_q == '0;
  assign push  = bus.ld_valid && !full;

  // ALU always wins; the FIFO head drains only on ALU-idle cycles
  always_comb begin
    sel_v  = 1'b0;
    sel_rd = '0;
    sel_d  = '0;
    pop    = 1'b0;
    unique case (1'b1)
      bus.alu_valid: begin
        sel_v  = 1'b1;
        sel_rd = bus.alu_rd;
        sel_d  = bus.alu_data;
      end
      (!bus.alu_valid && !empty): begin
        sel_v  = 1'b1;
        sel_rd = mem_rd[rptr_q];
        sel_d  = mem_d[rptr_q];
        pop    = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr = sel_v && (sel_rd != 5'd0);

  always_comb begin
    pend_nxt = pend_q;
    if (wr)
      pend_nxt[sel_rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 5'd0)
      pend_nxt[bus.iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr_q] <= bus.ld_rd;
      mem_d[wptr_q]  <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      wb_we_q <= 1'b0;
      wb_rd_q <= '0;
      wb_d_q  <= '0;
      pend_q  <= '0;
    end else begin
      if (push)
        wptr_q <= wptr_q + AW'(1);
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      wb_we_q <= wr;
      if (wr) begin
        wb_rd_q <= sel_rd;
        wb_d_q  <= sel_d;
      end
      pend_q <= pend_nxt;
    end
  end

  function automatic logic busy(input logic [4:0] x);
    return (x != 5'd0) &&
           (pend_q[x] || (wb_we_q && wb_rd_q == x));
  endfunction

  assign bus.ld_ready = !full;
  assign bus.ld_count = cnt_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_wdata = wb_d_q;
  assign bus.rs1_busy = busy(bus.rs1);
  assign bus.rs2_busy = busy(bus.rs2);
  assign bus.rd_busy  = busy(bus.iss_rd);
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  wb_arbiter_if #(.XLEN(XLEN), .LD_DEPTH(DEPTH)) bus ();

  wb_arbiter #(.XLEN(XLEN), .LD_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_d;
  logic        m_pend[32];
  bit          m_ok = 0;

  // Reference: queue of loads, one result per edge, ALU first
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_we = 0;
      m_rd = 0;
      m_d  = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_ok = 1;
    end else if (m_ok) begin
      int   pre;
      bit   have;
      ent_t s;
      pre  = mq.size();
      have = 0;
      if (bus.alu_valid) begin
        have = 1;
        s.rd = bus.alu_rd;
        s.d  = bus.alu_data;
      end else if (pre > 0) begin
        have = 1;
        s = mq.pop_front();
      end
      if (bus.ld_valid && pre < DEPTH)
        mq.push_back('{bus.ld_rd, bus.ld_data});
      if (have && s.rd != 0) begin
        m_we = 1;
        m_rd = s.rd;
        m_d  = s.d;
        m_pend[s.rd] = 0;
      end else begin
        m_we = 0;
      end
      if (bus.iss_valid && bus.iss_rd != 0)
        m_pend[bus.iss_rd] = 1;
    end
  end

  function automatic logic m_busy(input logic [4:0] x);
    return x != 0 && (m_pend[x] || (m_we && m_rd == x));
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      chk("wb_we", 32'(bus.wb_we), 32'(m_we));
      chk("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
      chk("wb_wdata", bus.wb_wdata, m_d);
      chk("ld_count", 32'(bus.ld_count), 32'(mq.size()));
      chk("ld_ready", 32'(bus.ld_ready), 32'(mq.size() < DEPTH));
      chk("rs1_busy", 32'(bus.rs1_busy), 32'(m_busy(bus.rs1)));
      chk("rs2_busy", 32'(bus.rs2_busy), 32'(m_busy(bus.rs2)));
      chk("rd_busy", 32'(bus.rd_busy), 32'(m_busy(bus.iss_rd)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 0;
    bus.ld_valid  = 0;
    bus.iss_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    bus.alu_rd = 0;   bus.alu_data = 0;
    bus.ld_rd = 0;    bus.ld_data = 0;
    bus.iss_rd = 0;   bus.rs1 = 5;  bus.rs2 = 9;

    // T1 reset
    tick(); tick();
    chk("t1_we", 32'(bus.wb_we), 0);
    chk("t1_ready", 32'(bus.ld_ready), 1);
    chk("t1_count", 32'(bus.ld_count), 0);
    chk("t1_busy", 32'({bus.rs1_busy, bus.rs2_busy, bus.rd_busy}), 0);
    rst_n = 1;
    tick();

    // T2 ALU write
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    tick();
    idle();
    chk("t2_we", 32'(bus.wb_we), 1);
    chk("t2_rd", 32'(bus.wb_rd), 5);
    chk("t2_data", bus.wb_wdata, 32'hDEADBEEF);
    tick();
    chk("t2_we_off", 32'(bus.wb_we), 0);

    // T3 collision
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 1;
    bus.ld_valid = 1;  bus.ld_rd = 7;  bus.ld_data = 2;
    tick();
    idle();
    chk("t3_rd_a", 32'(bus.wb_rd), 3);
    chk("t3_d_a", bus.wb_wdata, 1);
    tick();
    chk("t3_we_b", 32'(bus.wb_we), 1);
    chk("t3_rd_b", 32'(bus.wb_rd), 7);
    chk("t3_d_b", bus.wb_wdata, 2);
    tick();

    // T4 backpressure then in-order drain
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h55;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1;
      bus.ld_rd    = 5'(8 + i);
      bus.ld_data  = 32'(32'h100 + i);
      tick();
    end
    chk("t4_ready", 32'(bus.ld_ready), 0);
    chk("t4_count", 32'(bus.ld_count), 4);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_drain_we", 32'(bus.wb_we), 1);
      chk("t4_drain_rd", 32'(bus.wb_rd), 32'(8 + i));
    end
    chk("t4_ready_end", 32'(bus.ld_ready), 1);
    tick();

    // T5 scoreboard
    bus.iss_valid = 1; bus.iss_rd = 9;
    tick();
    bus.iss_valid = 0; bus.iss_rd = 0; bus.rs1 = 9;
    #1;
    chk("t5_busy_iss", 32'(bus.rs1_busy), 1);
    bus.ld_valid = 1; bus.ld_rd = 9; bus.ld_data = 32'h99;
    tick();
    bus.ld_valid = 0;
    #1;
    chk("t5_busy_q", 32'(bus.rs1_busy), 1);
    tick();
    chk("t5_wb_rd", 32'(bus.wb_rd), 9);
    chk("t5_busy_wb", 32'(bus.rs1_busy), 1);
    tick();
    chk("t5_busy_done", 32'(bus.rs1_busy), 0);
    bus.iss_valid = 1; bus.iss_rd = 0; bus.rs1 = 0;
    tick();
    bus.iss_valid = 0;
    #1;
    chk("t5_rd0_rs1", 32'(bus.rs1_busy), 0);
    chk("t5_rd0_rd", 32'(bus.rd_busy), 0);

    // T6 rd=0 load is consumed silently
    bus.ld_valid = 1; bus.ld_rd = 0; bus.ld_data = 32'hBAD;
    tick();
    bus.ld_valid = 0;
    tick();
    chk("t6_rd0_we", 32'(bus.wb_we), 0);
    chk("t6_rd0_cnt", 32'(bus.ld_count), 0);
    chk("t6_rd0_hold", 32'(bus.wb_rd), 9);

    // T6 reset mid-drain
    bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1;
      bus.ld_rd    = 5'(20 + i);
      bus.ld_data  = 32'(i);
      tick();
    end
    idle();
    tick();
    chk("t6_mid_cnt", 32'(bus.ld_count), 2);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t6_rst_we", 32'(bus.wb_we), 0);
    chk("t6_rst_cnt", 32'(bus.ld_count), 0);
    tick();
    chk("t6_post_we", 32'(bus.wb_we), 0);
    tick();

    // Mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      bus.alu_valid = (i % 4 == 0) || (i % 7 == 1);
      bus.alu_rd    = 5'(i);
      bus.alu_data  = 32'(i * 32'h1111);
      bus.ld_valid  = (i % 3 != 2);
      bus.ld_rd     = 5'(i + 3);
      bus.ld_data   = ~32'(i);
      bus.iss_valid = (i % 5 == 0);
      bus.iss_rd    = 5'(i * 7);
      bus.rs1       = 5'(i * 3);
      bus.rs2       = 5'(i + 1);
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
